// File: rtl/alu_cmd_issuer_if.sv
// Command and response streams between a command source and the ALU command issuer.
interface alu_cmd_issuer_if #(
    parameter int TAG_W = 4
);
    logic                    cmd_valid;
    logic                    cmd_ready;
    logic [2:0]              cmd_opcode;
    logic signed [3:0]       cmd_a;
    logic signed [3:0]       cmd_b;
    logic [TAG_W-1:0]        cmd_tag;

    logic                    rsp_valid;
    logic                    rsp_ready;
    logic [5:0]              rsp_data;
    logic                    rsp_ovf;
    logic                    rsp_zero;
    logic [TAG_W-1:0]        rsp_tag;

    // Host side: offers commands, consumes responses.
    modport master (
        output cmd_valid, cmd_opcode, cmd_a, cmd_b, cmd_tag, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_data, rsp_ovf, rsp_zero, rsp_tag
    );

    // Issuer side: accepts commands, produces responses.
    modport slave (
        input  cmd_valid, cmd_opcode, cmd_a, cmd_b, cmd_tag, rsp_ready,
        output cmd_ready, rsp_valid, rsp_data, rsp_ovf, rsp_zero, rsp_tag
    );
endinterface

// File: rtl/alu_cmd_issuer.sv
// ALU command issuer: buffers commands in a FIFO, drives one at a time onto the
// combinational ALU, captures its result one cycle later and returns it with the tag.
module alu_cmd_issuer #(
    parameter int DEPTH = 4,
    parameter int TAG_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    alu_cmd_issuer_if.slave   bus,
    output logic signed [3:0] src_a,
    output logic signed [3:0] src_b,
    output logic [2:0]        opcode,
    input  logic [5:0]        alu_out,
    input  logic              overflow,
    input  logic              zero,
    output logic              busy,
    output logic [15:0]       op_count,
    output logic [7:0]        ovf_count,
    input  logic              cnt_clr
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t            state;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic              fifo_empty;
    logic              fifo_full;
    logic              push;
    logic              pop;
    logic [TAG_W-1:0]  tag_p0;

    logic [2:0]        fifo_op  [DEPTH];
    logic signed [3:0] fifo_a   [DEPTH];
    logic signed [3:0] fifo_b   [DEPTH];
    logic [TAG_W-1:0]  fifo_tag [DEPTH];

    // Overflow statistic holds at its ceiling instead of wrapping.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    assign fifo_empty    = (count == '0);
    assign fifo_full     = (count == FULL_CNT);
    assign bus.cmd_ready = !fifo_full;
    assign push          = bus.cmd_valid && !fifo_full;
    // RESP always has rsp_valid high, so rsp_ready alone completes the handshake there.
    assign pop           = !fifo_empty && ((state == IDLE) || ((state == RESP) && bus.rsp_ready));
    assign busy          = (state != IDLE) || !fifo_empty;

    // FIFO storage: data only, written on push.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_op[wr_ptr]  <= bus.cmd_opcode;
            fifo_a[wr_ptr]   <= bus.cmd_a;
            fifo_b[wr_ptr]   <= bus.cmd_b;
            fifo_tag[wr_ptr] <= bus.cmd_tag;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at power-of-2 depth.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Issue FSM with registered ALU drive, response capture and statistics.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            src_a         <= '0;
            src_b         <= '0;
            opcode        <= '0;
            tag_p0        <= '0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_data  <= '0;
            bus.rsp_ovf   <= 1'b0;
            bus.rsp_zero  <= 1'b0;
            bus.rsp_tag   <= '0;
            op_count      <= '0;
            ovf_count     <= '0;
        end else begin
            if (cnt_clr) begin
                op_count  <= '0;
                ovf_count <= '0;
            end else if (state == EXEC) begin
                op_count <= op_count + 16'd1;
                if (overflow) ovf_count <= sat_inc8(ovf_count);
            end

            case (state)
                IDLE: begin
                    // p0: head of FIFO driven onto the ALU
                    if (pop) begin
                        src_a  <= fifo_a[rd_ptr];
                        src_b  <= fifo_b[rd_ptr];
                        opcode <= fifo_op[rd_ptr];
                        tag_p0 <= fifo_tag[rd_ptr];
                        state  <= EXEC;
                    end
                end
                EXEC: begin
                    // p1: ALU result settled, captured into the response
                    bus.rsp_data  <= alu_out;
                    bus.rsp_ovf   <= overflow;
                    bus.rsp_zero  <= zero;
                    bus.rsp_tag   <= tag_p0;
                    bus.rsp_valid <= 1'b1;
                    state         <= RESP;
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        bus.rsp_valid <= 1'b0;
                        if (pop) begin
                            src_a  <= fifo_a[rd_ptr];
                            src_b  <= fifo_b[rd_ptr];
                            opcode <= fifo_op[rd_ptr];
                            tag_p0 <= fifo_tag[rd_ptr];
                            state  <= EXEC;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/alu_cmd_issuer.md
Name: alu_cmd_issuer

Overview:
Initiator-side controller for the team's combinational 4-bit signed ALU (opcodes 000..111, 6-bit signed result, overflow, zero).
- Accepts operation commands on a valid/ready stream and buffers them in a small FIFO.
- Drives one command at a time onto the ALU operand/opcode ports, captures the ALU result one cycle later, and returns it on a valid/ready response stream.
- Keeps operation and overflow statistics.
- Sits between a command source (testbench, host, or sequencer) and the ALU instance.

Parameters:
DEPTH, 4, command FIFO entries (power of 2, >=2)
TAG_W, 4, width of the user tag carried from command to response

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
cmd_valid  in  1  command offered
cmd_ready  out  1  command FIFO can accept
cmd_opcode  in  3  ALU opcode
cmd_a  in  4  signed operand A
cmd_b  in  4  signed operand B
cmd_tag  in  TAG_W  user tag
src_a  out  4  to ALU src_a (registered)
src_b  out  4  to ALU src_b (registered)
opcode  out  3  to ALU opcode (registered)
alu_out  in  6  from ALU result
overflow  in  1  from ALU overflow
zero  in  1  from ALU zero
rsp_valid  out  1  response available
rsp_ready  in  1  consumer accepts response
rsp_data  out  6  captured alu_out
rsp_ovf  out  1  captured overflow
rsp_zero  out  1  captured zero
rsp_tag  out  TAG_W  tag of the originating command
busy  out  1  FIFO non-empty or FSM not IDLE
op_count  out  16  completed captures, wraps
ovf_count  out  8  captures with overflow=1, saturates at 255
cnt_clr  in  1  synchronous clear of both counters

Behaviour:
- Reset (async, rst_n=0):
  - FSM goes to IDLE and the FIFO is emptied.
  - src_a, src_b, opcode, rsp_* and rsp_valid are all 0.
  - Both counters are 0 and busy is 0.
- Command FIFO:
  - cmd_ready = !full (combinational from count).
  - Push on cmd_valid && cmd_ready.
  - No push when full; there is no bypass path.
  - Simultaneous push and pop with 0 < count < DEPTH leaves count unchanged.
  - Pointers wrap modulo DEPTH.
  - Commands issue in strict FIFO order.
- FSM states: IDLE, EXEC, RESP.
  - IDLE:
    - If the FIFO is non-empty: pop the head, register cmd_a/cmd_b/cmd_opcode onto src_a/src_b/opcode, latch the tag internally, and go to EXEC.
    - Otherwise stay in IDLE.
  - EXEC (exactly 1 cycle, ALU settle):
    - At the edge, capture alu_out/overflow/zero into rsp_data/rsp_ovf/rsp_zero and the latched tag into rsp_tag.
    - Set rsp_valid=1.
    - Increment op_count; increment ovf_count if overflow=1 and not at 255.
    - Go to RESP.
  - RESP:
    - Hold all rsp_* stable while rsp_ready=0.
    - On rsp_valid && rsp_ready: clear rsp_valid.
    - If the FIFO is non-empty in the same cycle, pop and drive the next command and go to EXEC; else go to IDLE.
- Drive registers: src_a/src_b/opcode hold their last value when not loading.
- Latency:
  - A command pushed into an empty idle block at edge N is driven to the ALU at edge N+1.
  - rsp_valid is high after edge N+2.
  - Back-to-back sustained throughput is one response per 2 cycles with rsp_ready tied high.
- Counters:
  - cnt_clr=1 zeroes both counters at the edge and takes priority over a same-cycle increment.
  - op_count wraps from 0xFFFF to 0.
- Reset mid-operation: in-flight and queued commands are discarded and no response is produced.
- busy = (state != IDLE) || (count != 0).

Test Plan:
1. Single ADD: opcode=100, a=3, b=4, tag=5, rsp_ready=1 -> rsp_valid 2 cycles after acceptance with rsp_data=000111, rsp_ovf=0, rsp_zero=0, rsp_tag=5, op_count=1.
2. MUL overflow: opcode=011, a=7, b=7 -> rsp_data=011111, rsp_ovf=1; ovf_count=1. Then SUB a=-8, b=7 -> rsp_data=110001, rsp_ovf=0.
3. Zero flag: AND a=0, b=-1 -> rsp_data=000000, rsp_zero=1.
4. Backpressure/full: rsp_ready=0, push 1+DEPTH commands (tags 0..4, DEPTH=4).
   - cmd_ready drops to 0 after the 5th accept; the 6th is held off.
   - rsp_tag=0 is stable the whole time.
   - Release rsp_ready -> tags 0..4 returned in order, one every 2 cycles.
5. Counter saturation and clear: 256 overflowing MULs -> ovf_count=255 (no wrap). Asserting cnt_clr in the same cycle as a capture -> both counters read 0.
6. Reset mid-operation: assert rst_n=0 while in RESP with 2 commands queued -> immediately rsp_valid=0, busy=0, cmd_ready=1, counters 0; no response follows after release.
